reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard_pkg.sv | 14 +
 rtl/reg_scoreboard_if.sv | 29 ++
 rtl/reg_addr_eq.sv | 12 +
 rtl/reg_scoreboard.sv | 84 ++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the register scoreboard.
package reg_scoreboard_pkg;

  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 2;
  localparam int TOTAL_W    = 6;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // Register 0 never has pending writes and is never tracked.
  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bus between the pipeline front end and the scoreboard.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic               issue_valid;
  logic               issue_we;
  reg_addr_t          issue_rd;
  reg_addr_t          issue_rs1;
  reg_addr_t          issue_rs2;
  logic               wb_valid;
  reg_addr_t          wb_rd;
  logic               stall;
  logic               busy_rs1;
  logic               busy_rs2;
  logic               issue_fire;
  logic [TOTAL_W-1:0] pending_total;
  logic               wb_err;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_rs1, issue_rs2, wb_valid, wb_rd,
    input  stall, busy_rs1, busy_rs2, issue_fire, pending_total, wb_err
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_rs1, issue_rs2, wb_valid, wb_rd,
    output stall, busy_rs1, busy_rs2, issue_fire, pending_total, wb_err
  );

endinterface

// File: rtl/reg_addr_eq.sv
// Register address match that never reports a hit on register 0.
module reg_addr_eq
  import reg_scoreboard_pkg::*;
(
  input  reg_addr_t a,
  input  reg_addr_t b,
  output logic      eq
);

  assign eq = (a == b) && (a != ZERO_REG);

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters with issue stall and writeback bypass.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREGS = reg_scoreboard_pkg::NREGS,
  parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  reg_scoreboard_if.slave  bus
);

  logic [CNT_W-1:0]   cnt_reg [NREGS];
  logic [TOTAL_W-1:0] pending_total_reg;
  logic               wb_err_reg;

  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd, cnt_wb;
  logic             rs1_wb_eq, rs2_wb_eq, rd_wb_eq;
  logic             busy_rs1, busy_rs2, rd_full, stall, fire;
  logic             inc_en, dec_en, err_set;
  logic [NREGS-1:1] inc_hit, dec_hit;

  reg_addr_eq u_rs1_eq (.a(bus.issue_rs1), .b(bus.wb_rd), .eq(rs1_wb_eq));
  reg_addr_eq u_rs2_eq (.a(bus.issue_rs2), .b(bus.wb_rd), .eq(rs2_wb_eq));
  reg_addr_eq u_rd_eq  (.a(bus.issue_rd),  .b(bus.wb_rd), .eq(rd_wb_eq));

  assign cnt_rs1 = cnt_reg[bus.issue_rs1];
  assign cnt_rs2 = cnt_reg[bus.issue_rs2];
  assign cnt_rd  = cnt_reg[bus.issue_rd];
  assign cnt_wb  = cnt_reg[bus.wb_rd];

  // A source whose last outstanding write retires this cycle is treated as ready.
  assign busy_rs1 = (bus.issue_rs1 != ZERO_REG) && (cnt_rs1 != '0) &&
                    !(bus.wb_valid && rs1_wb_eq && (cnt_rs1 == CNT_W'(1)));
  assign busy_rs2 = (bus.issue_rs2 != ZERO_REG) && (cnt_rs2 != '0) &&
                    !(bus.wb_valid && rs2_wb_eq && (cnt_rs2 == CNT_W'(1)));

  // A saturated destination counter may still accept a write if one retires now.
  assign rd_full = bus.issue_we && (bus.issue_rd != ZERO_REG) && (cnt_rd == '1) &&
                   !(bus.wb_valid && rd_wb_eq);

  assign stall = bus.issue_valid && (busy_rs1 || busy_rs2 || rd_full);
  assign fire  = bus.issue_valid && !stall;

  assign inc_en  = fire && bus.issue_we && (bus.issue_rd != ZERO_REG);
  assign dec_en  = bus.wb_valid && (bus.wb_rd != ZERO_REG) && (cnt_wb != '0);
  assign err_set = bus.wb_valid && (bus.wb_rd != ZERO_REG) && (cnt_wb == '0);

  // Decode the increment/decrement targets into one-hot per-register strobes.
  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_sel
      assign inc_hit[gi] = inc_en && (bus.issue_rd == REG_ADDR_W'(gi));
      assign dec_hit[gi] = dec_en && (bus.wb_rd == REG_ADDR_W'(gi));
    end
  endgenerate

  // Counter array, running total and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) cnt_reg[i] <= '0;
      pending_total_reg <= '0;
      wb_err_reg        <= 1'b0;
    end else begin
      cnt_reg[0] <= '0;
      for (int i = 1; i < NREGS; i++) begin
        if (inc_hit[i] && !dec_hit[i])
          cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
        else if (dec_hit[i] && !inc_hit[i])
          cnt_reg[i] <= cnt_reg[i] - CNT_W'(1);
      end
      pending_total_reg <= pending_total_reg + TOTAL_W'(inc_en) - TOTAL_W'(dec_en);
      if (err_set) wb_err_reg <= 1'b1;
    end
  end

  assign bus.stall         = stall;
  assign bus.busy_rs1      = busy_rs1;
  assign bus.busy_rs2      = busy_rs2;
  assign bus.issue_fire    = fire;
  assign bus.pending_total = pending_total_reg;
  assign bus.wb_err        = wb_err_reg;

endmodule
